gear_deploy_ctrl: RTL and testbench

// Parametrised landing-gear controller; successor to the single-threshold deploy FSM.
// - Consumes ultrasonic distance samples; drives the servo angle select, LED and LCD status.
// - Adds hysteresis, N-sample confirmation and a timed servo-travel phase.
// - Adds a sensor watchdog with fail-safe deploy, and a manual override.

---
 rtl/gear_ctrl_pkg.sv | 17 +
 rtl/gear_sample_qual.sv | 74 +++++++
 rtl/gear_deploy_ctrl.sv | 106 ++++++++++
 tb/tb_gear_deploy_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gear_ctrl_pkg.sv
// Shared encodings for the landing-gear controller and its LCD status driver.
package gear_ctrl_pkg;

   // Gear position states; the numeric values are visible on state_code.
   typedef enum logic [1:0] {
      ST_UP       = 2'd0,
      ST_LOWERING = 2'd1,
      ST_DOWN     = 2'd2,
      ST_RAISING  = 2'd3
   } gear_state_t;

   // True while the servo is physically moving the gear.
   function automatic logic is_transit(input gear_state_t s);
      return (s == ST_LOWERING) || (s == ST_RAISING);
   endfunction

endpackage

// File: rtl/gear_sample_qual.sv
// Distance-sample qualifier: hysteresis compare, N-sample confirmation and
// sensor watchdog. sample_valid is a one-cycle strobe with no back-pressure:
// distance_raw is consumed on every clk edge where sample_valid=1 and ignored
// otherwise.
module gear_sample_qual
   import gear_ctrl_pkg::*;
#(
   parameter int DW          = 20,
   parameter int DEPLOY_TH   = 58000,
   parameter int RETRACT_TH  = 72500,
   parameter int CONFIRM_N   = 4,
   parameter int TIMEOUT_CYC = 5000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_valid,
   input  logic [DW-1:0] distance_raw,
   output logic          sens_dn,
   output logic          sens_up,
   output logic          fault
);

   localparam int CW = $clog2(CONFIRM_N + 1);
   localparam int WW = $clog2(TIMEOUT_CYC);

   localparam logic [DW-1:0] DEP_TH   = DW'(DEPLOY_TH);
   localparam logic [DW-1:0] RET_TH   = DW'(RETRACT_TH);
   localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRM_N);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] lo_cnt;
   logic [CW-1:0] hi_cnt;
   logic [WW-1:0] wd_cnt;

   // Confirmation counters: consecutive near / far samples, saturating; the
   // hysteresis band between the thresholds breaks both runs.
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_cnt <= '0;
         hi_cnt <= '0;
      end else if (sample_valid) begin
         if (distance_raw < DEP_TH) begin
            hi_cnt <= '0;
            if (lo_cnt != CONF_MAX) lo_cnt <= lo_cnt + 1'b1;
         end else if (distance_raw >= RET_TH) begin
            lo_cnt <= '0;
            if (hi_cnt != CONF_MAX) hi_cnt <= hi_cnt + 1'b1;
         end else begin
            lo_cnt <= '0;
            hi_cnt <= '0;
         end
      end
   end

   // Watchdog: a sample always wins over the terminal count; the count holds
   // at its last value while fault is up so it never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         fault  <= 1'b0;
      end else if (sample_valid) begin
         wd_cnt <= '0;
         fault  <= 1'b0;
      end else if (wd_cnt == WD_LAST) begin
         fault  <= 1'b1;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   assign sens_dn = (lo_cnt == CONF_MAX);
   assign sens_up = (hi_cnt == CONF_MAX);

endmodule

// File: rtl/gear_deploy_ctrl.sv
// Landing-gear controller: command arbitration (fault > manual > sensor),
// UP/LOWERING/DOWN/RAISING FSM with timed servo travel, Moore output decode.
module gear_deploy_ctrl
   import gear_ctrl_pkg::*;
#(
   parameter int DW          = 20,
   parameter int DEPLOY_TH   = 58000,
   parameter int RETRACT_TH  = 72500,
   parameter int CONFIRM_N   = 4,
   parameter int TRAVEL_CYC  = 50000000,
   parameter int TIMEOUT_CYC = 5000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_valid,
   input  logic [DW-1:0] distance_raw,
   input  logic          manual_req,
   input  logic          manual_deploy,
   output logic          angle_sel,
   output logic          gear_down,
   output logic          in_transit,
   output logic          fault,
   output logic [1:0]    state_code
);

   localparam int TW = $clog2(TRAVEL_CYC);
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);

   gear_state_t   state;
   gear_state_t   state_nxt;
   logic [TW-1:0] timer;
   logic          sens_dn;
   logic          sens_up;
   logic          dn_cmd;
   logic          up_cmd;
   logic          travel_done;

   gear_sample_qual #(
      .DW          (DW),
      .DEPLOY_TH   (DEPLOY_TH),
      .RETRACT_TH  (RETRACT_TH),
      .CONFIRM_N   (CONFIRM_N),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_qual (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .distance_raw (distance_raw),
      .sens_dn      (sens_dn),
      .sens_up      (sens_up),
      .fault        (fault)
   );

   // Command arbitration: a dead sensor forces deploy, then manual, then sensor.
   always_comb begin
      dn_cmd = sens_dn;
      up_cmd = sens_up;
      if (fault) begin
         dn_cmd = 1'b1;
         up_cmd = 1'b0;
      end else if (manual_req) begin
         dn_cmd = manual_deploy;
         up_cmd = !manual_deploy;
      end
   end

   assign travel_done = (timer == TRAVEL_LAST);

   // Next-state logic; a deploy in progress is never aborted.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_UP:       if (dn_cmd) state_nxt = ST_LOWERING;
         ST_LOWERING: if (travel_done) state_nxt = ST_DOWN;
         ST_DOWN:     if (up_cmd && !dn_cmd) state_nxt = ST_RAISING;
         ST_RAISING: begin
            if (dn_cmd)           state_nxt = ST_LOWERING;
            else if (travel_done) state_nxt = ST_UP;
         end
         default:     state_nxt = ST_UP;
      endcase
   end

   // State register; reset abandons any move in progress.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_UP;
      else     state <= state_nxt;
   end

   // Travel timer: restarts on every state change, counts while moving,
   // holds at its last value rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         timer <= '0;
      else if (state_nxt != state)
         timer <= '0;
      else if (is_transit(state) && !travel_done)
         timer <= timer + 1'b1;
   end

   assign angle_sel  = (state == ST_LOWERING) || (state == ST_DOWN);
   assign gear_down  = (state == ST_DOWN);
   assign in_transit = is_transit(state);
   assign state_code = state;

endmodule

// File: tb/tb_gear_deploy_ctrl.sv
// Directed bench for gear_deploy_ctrl with short travel / timeout parameters.
module tb_gear_deploy_ctrl;

   localparam int DW          = 20;
   localparam int DEPLOY_TH   = 58000;
   localparam int RETRACT_TH  = 72500;
   localparam int CONFIRM_N   = 3;
   localparam int TRAVEL_CYC  = 10;
   localparam int TIMEOUT_CYC = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_valid;
   logic [DW-1:0] distance_raw;
   logic          manual_req;
   logic          manual_deploy;
   logic          angle_sel;
   logic          gear_down;
   logic          in_transit;
   logic          fault;
   logic [1:0]    state_code;

   int n_tests = 0;
   int n_fail  = 0;

   // Clock: 100 MHz nominal; inputs change and outputs are sampled on negedge.
   always #5 clk = ~clk;

   gear_deploy_ctrl #(
      .DW          (DW),
      .DEPLOY_TH   (DEPLOY_TH),
      .RETRACT_TH  (RETRACT_TH),
      .CONFIRM_N   (CONFIRM_N),
      .TRAVEL_CYC  (TRAVEL_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_valid  (sample_valid),
      .distance_raw  (distance_raw),
      .manual_req    (manual_req),
      .manual_deploy (manual_deploy),
      .angle_sel     (angle_sel),
      .gear_down     (gear_down),
      .in_transit    (in_transit),
      .fault         (fault),
      .state_code    (state_code)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected {angle_sel, gear_down, in_transit, state_code} for a state.
   function automatic logic [4:0] expect_outs(input logic [1:0] s);
      return {(s == 2'd1) || (s == 2'd2), s == 2'd2, (s == 2'd1) || (s == 2'd3), s};
   endfunction

   task automatic check_state(input string tag, input logic [1:0] s);
      check(tag, {27'd0, angle_sel, gear_down, in_transit, state_code}, {27'd0, expect_outs(s)});
   endtask

   task automatic check_fault(input string tag, input logic exp);
      check(tag, {31'd0, fault}, {31'd0, exp});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the negedge after the reset edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One-cycle sample strobe; returns one cycle later.
   task automatic pulse(input int d);
      sample_valid = 1'b1;
      distance_raw = DW'(d);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // Sample followed by the normal 5-clock sample spacing.
   task automatic sample(input int d);
      pulse(d);
      idle(4);
   endtask

   initial begin
      rst = 1'b1;
      sample_valid = 1'b0;
      distance_raw = '0;
      manual_req = 1'b0;
      manual_deploy = 1'b0;

      // Reset state and basic deploy latency.
      do_reset();
      check_state("reset_outs", 2'd0);
      check_fault("reset_fault", 1'b0);
      sample(50000);
      sample(50000);
      pulse(50000);
      check_state("t1_pre_lower", 2'd0);
      idle(1);
      check_state("t1_lower", 2'd1);
      idle(9);
      check_state("t1_travel_t9", 2'd1);
      idle(1);
      check_state("t1_down", 2'd2);

      // Hysteresis band breaks the confirmation run.
      do_reset();
      sample(50000);
      sample(50000);
      sample(65000);
      sample(50000);
      check_state("t2_band_no_deploy", 2'd0);
      sample(50000);
      pulse(50000);
      idle(1);
      check_state("t2_deploy", 2'd1);

      // Retract, then reversal mid-raise restarts the travel timer.
      do_reset();
      sample(50000);
      sample(50000);
      pulse(50000);
      idle(1);
      sample(50000);
      sample(50000);
      check_state("t3_down", 2'd2);
      sample(80000);
      sample(80000);
      pulse(80000);
      check_state("t3_pre_raise", 2'd2);
      idle(1);
      check_state("t3_raise", 2'd3);
      idle(4);
      check_state("t3_raise_t4", 2'd3);
      pulse(40000);
      pulse(40000);
      pulse(40000);
      check_state("t3_pre_reverse", 2'd3);
      idle(1);
      check_state("t3_reverse", 2'd1);
      idle(9);
      check_state("t3_relower_t9", 2'd1);
      idle(1);
      check_state("t3_down_again", 2'd2);

      // Watchdog timeout forces deploy; a sample clears fault.
      do_reset();
      idle(19);
      check_fault("t4_wd_edge_clear", 1'b0);
      idle(1);
      check_fault("t4_wd_fault", 1'b1);
      check_state("t4_fault_still_up", 2'd0);
      idle(1);
      check_state("t4_fault_lower", 2'd1);
      idle(10);
      check_state("t4_fault_down", 2'd2);
      pulse(80000);
      check_fault("t4_sample_clears", 1'b0);
      check_state("t4_stays_down", 2'd2);
      idle(4);
      check_state("t4_still_down", 2'd2);

      // Sample on the terminal-count cycle wins; watchdog restarts from it.
      do_reset();
      idle(19);
      pulse(80000);
      check_fault("t4b_tc_sample_wins", 1'b0);
      check_state("t4b_no_deploy", 2'd0);
      idle(19);
      check_fault("t4b_restart_edge", 1'b0);
      idle(1);
      check_fault("t4b_restart_fault", 1'b1);

      // Manual override beats sensor; fault beats manual.
      do_reset();
      manual_req = 1'b1;
      manual_deploy = 1'b1;
      idle(1);
      check_state("t5_man_lower", 2'd1);
      idle(10);
      check_state("t5_man_down", 2'd2);
      manual_deploy = 1'b0;
      pulse(40000);
      check_state("t5_man_raise", 2'd3);
      pulse(40000);
      pulse(40000);
      idle(1);
      check_state("t5_sensor_ignored", 2'd3);
      idle(6);
      check_state("t5_raise_t9", 2'd3);
      idle(1);
      check_state("t5_up", 2'd0);
      idle(11);
      check_fault("t5_pre_fault", 1'b0);
      idle(1);
      check_fault("t5_fault", 1'b1);
      idle(1);
      check_state("t5_fault_lower", 2'd1);

      // Reset mid-lowering abandons the move.
      idle(2);
      check_state("t6_mid_lower", 2'd1);
      rst = 1'b1;
      @(negedge clk);
      check_state("t6_reset_outs", 2'd0);
      check_fault("t6_reset_fault", 1'b0);
      rst = 1'b0;
      manual_req = 1'b0;
      idle(1);
      check_state("t6_after_reset", 2'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
